// File: rtl/io_arbiter.sv
// io-card access arbiter: CPU accesses pass through combinationally when granted,
// host accesses run as latched setup/strobe/done transactions with alternating priority.
module io_arbiter #(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_cpuIoNCE,
  input  logic [7:0] i_cpuIoAddress,
  input  logic       i_cpuIoNOE,
  input  logic       i_cpuIoNWE,
  output logic       o_cpuWait,
  input  logic       i_hostReq,
  input  logic       i_hostWE,
  input  logic [7:0] i_hostAddr,
  input  logic [7:0] i_hostWData,
  output logic       o_hostAck,
  output logic [7:0] o_hostRData,
  input  logic [7:0] i_bus,
  output logic [7:0] o_bus,
  output logic       o_busNOE,
  output logic       o_ioNCE,
  output logic       o_ioNOE,
  output logic       o_ioNWE,
  output logic [7:0] o_ioAddress
);

  typedef enum logic [2:0] {
    IDLE,
    CPU,
    HSETUP,
    HSTROBE,
    HDONE
  } state_t;

  typedef enum logic {
    GRANT_CPU,
    GRANT_HOST
  } grant_t;

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  state_t     state;
  grant_t     last_grant;
  logic [3:0] count;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic [7:0] rdata;
  logic       cpu_req;
  logic       grant_cpu;

  assign cpu_req = ~i_cpuIoNCE;

  // On a tie in IDLE the CPU loses only if it was the side granted last.
  assign grant_cpu = (state == CPU) ||
                     ((state == IDLE) && cpu_req &&
                      !(i_hostReq && (last_grant == GRANT_CPU)));

  assign o_cpuWait   = cpu_req & ~grant_cpu;
  assign o_hostAck   = (state == HDONE);
  assign o_hostRData = rdata;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state      <= IDLE;
      last_grant <= GRANT_HOST;
      count      <= '0;
      host_we    <= 1'b0;
      host_addr  <= '0;
      host_wdata <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_cpu) begin
            state      <= CPU;
            last_grant <= GRANT_CPU;
          end else if (i_hostReq) begin
            state      <= HSETUP;
            last_grant <= GRANT_HOST;
            host_we    <= i_hostWE;
            host_addr  <= i_hostAddr;
            host_wdata <= i_hostWData;
          end
        end
        CPU: begin
          if (!cpu_req) begin
            state <= IDLE;
          end
        end
        HSETUP: begin
          state <= HSTROBE;
          count <= STROBE_LOAD;
        end
        HSTROBE: begin
          if (count == 4'd0) begin
            state <= HDONE;
            if (!host_we) begin
              rdata <= i_bus;
            end
          end else begin
            count <= count - 4'd1;
          end
        end
        HDONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    o_ioNCE     = 1'b1;
    o_ioNOE     = 1'b1;
    o_ioNWE     = 1'b1;
    o_ioAddress = '0;
    o_busNOE    = 1'b1;
    o_bus       = '0;
    if (grant_cpu) begin
      o_ioNCE     = i_cpuIoNCE;
      o_ioNOE     = i_cpuIoNOE;
      o_ioNWE     = i_cpuIoNWE;
      o_ioAddress = i_cpuIoAddress;
    end else begin
      case (state)
        HSETUP, HSTROBE, HDONE: begin
          o_ioNCE     = 1'b0;
          o_ioAddress = host_addr;
          if (state == HSTROBE) begin
            o_ioNOE = host_we;
            o_ioNWE = ~host_we;
          end
          if (host_we) begin
            o_busNOE = 1'b0;
            o_bus    = host_wdata;
          end
        end
        default: begin
          o_ioNCE = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_arbiter.sv
// Scoreboard bench for io_arbiter: stimulus pushes the hand-computed per-cycle
// output vector, a negedge monitor pops and compares it against the DUT.
module tb_io_arbiter;

  logic       i_clk = 1'b0;
  logic       i_resetn;
  logic       i_cpuIoNCE;
  logic [7:0] i_cpuIoAddress;
  logic       i_cpuIoNOE;
  logic       i_cpuIoNWE;
  logic       o_cpuWait;
  logic       i_hostReq;
  logic       i_hostWE;
  logic [7:0] i_hostAddr;
  logic [7:0] i_hostWData;
  logic       o_hostAck;
  logic [7:0] o_hostRData;
  logic [7:0] i_bus;
  logic [7:0] o_bus;
  logic       o_busNOE;
  logic       o_ioNCE;
  logic       o_ioNOE;
  logic       o_ioNWE;
  logic [7:0] o_ioAddress;

  always #5 i_clk = ~i_clk;

  io_arbiter #(.STROBE_CYCLES(2)) dut (
    .i_clk          (i_clk),
    .i_resetn       (i_resetn),
    .i_cpuIoNCE     (i_cpuIoNCE),
    .i_cpuIoAddress (i_cpuIoAddress),
    .i_cpuIoNOE     (i_cpuIoNOE),
    .i_cpuIoNWE     (i_cpuIoNWE),
    .o_cpuWait      (o_cpuWait),
    .i_hostReq      (i_hostReq),
    .i_hostWE       (i_hostWE),
    .i_hostAddr     (i_hostAddr),
    .i_hostWData    (i_hostWData),
    .o_hostAck      (o_hostAck),
    .o_hostRData    (o_hostRData),
    .i_bus          (i_bus),
    .o_bus          (o_bus),
    .o_busNOE       (o_busNOE),
    .o_ioNCE        (o_ioNCE),
    .o_ioNOE        (o_ioNOE),
    .o_ioNWE        (o_ioNWE),
    .o_ioAddress    (o_ioAddress)
  );

  // Vector layout: {NCE,NOE,NWE, addr[8], wait, ack, busNOE, bus[8], rdata[8]}
  typedef struct {
    string       tag;
    logic [29:0] v;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [29:0] act;
  logic [7:0]  xr = 8'h00;
  int          total = 0;
  int          bad = 0;

  task automatic step(input string tag, input logic [2:0] strb, input logic [7:0] addr,
                      input logic wt, input logic ack, input logic bnoe, input logic [7:0] bus);
    exp_t n;
    n.tag = tag;
    n.v   = {strb, addr, wt, ack, bnoe, bus, xr};
    q.push_back(n);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic wt);
    step(tag, 3'b111, 8'h00, wt, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic cpu_set(input logic nce, input logic [7:0] addr, input logic noe, input logic nwe);
    i_cpuIoNCE     = nce;
    i_cpuIoAddress = addr;
    i_cpuIoNOE     = noe;
    i_cpuIoNWE     = nwe;
  endtask

  task automatic host_set(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
    i_hostReq   = req;
    i_hostWE    = we;
    i_hostAddr  = addr;
    i_hostWData = wd;
  endtask

  initial begin
    forever begin
      @(negedge i_clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {o_ioNCE, o_ioNOE, o_ioNWE, o_ioAddress, o_cpuWait, o_hostAck,
               o_busNOE, o_bus, o_hostRData};
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s: actual=%h required=%h", e.tag, act, e.v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    i_resetn = 1'b0;
    cpu_set(1'b1, 8'h00, 1'b1, 1'b1);
    host_set(1'b0, 1'b0, 8'h00, 8'h00);
    i_bus = 8'h00;
    @(posedge i_clk);
    #1;

    idle("reset0", 1'b0);
    idle("reset1", 1'b0);
    i_resetn = 1'b1;
    idle("post_reset", 1'b0);

    // Uncontended CPU write: zero-latency mirror
    cpu_set(1'b0, 8'h12, 1'b1, 1'b0);
    step("cpu_wr", 3'b010, 8'h12, 1'b0, 1'b0, 1'b1, 8'h00);
    cpu_set(1'b1, 8'h00, 1'b1, 1'b1);
    idle("cpu_rel", 1'b0);

    // Host read; request dropped and address changed after acceptance
    host_set(1'b1, 1'b0, 8'h05, 8'h00);
    idle("rd_idle", 1'b0);
    host_set(1'b0, 1'b0, 8'hFF, 8'h00);
    step("rd_setup", 3'b011, 8'h05, 1'b0, 1'b0, 1'b1, 8'h00);
    i_bus = 8'h5A;
    step("rd_strb1", 3'b001, 8'h05, 1'b0, 1'b0, 1'b1, 8'h00);
    i_bus = 8'hA7;
    step("rd_strb2", 3'b001, 8'h05, 1'b0, 1'b0, 1'b1, 8'h00);
    i_bus = 8'h00;
    xr = 8'hA7;
    step("rd_done", 3'b011, 8'h05, 1'b0, 1'b1, 1'b1, 8'h00);
    idle("rd_after", 1'b0);

    // Host write 0x3C to 0x80
    host_set(1'b1, 1'b1, 8'h80, 8'h3C);
    idle("wr_idle", 1'b0);
    step("wr_setup", 3'b011, 8'h80, 1'b0, 1'b0, 1'b0, 8'h3C);
    step("wr_strb1", 3'b010, 8'h80, 1'b0, 1'b0, 1'b0, 8'h3C);
    step("wr_strb2", 3'b010, 8'h80, 1'b0, 1'b0, 1'b0, 8'h3C);
    step("wr_done", 3'b011, 8'h80, 1'b0, 1'b1, 1'b0, 8'h3C);
    host_set(1'b0, 1'b1, 8'h80, 8'h3C);
    idle("wr_after", 1'b0);

    // Contention: both request in every IDLE decision; grants alternate
    i_bus = 8'h99;
    host_set(1'b1, 1'b0, 8'h44, 8'h00);
    cpu_set(1'b0, 8'h21, 1'b0, 1'b1);
    step("arb0_cpu", 3'b001, 8'h21, 1'b0, 1'b0, 1'b1, 8'h00);
    cpu_set(1'b1, 8'h00, 1'b1, 1'b1);
    idle("arb0_rel", 1'b0);
    cpu_set(1'b0, 8'h22, 1'b0, 1'b1);
    idle("arb1_pick", 1'b1);
    step("arb1_setup", 3'b011, 8'h44, 1'b1, 1'b0, 1'b1, 8'h00);
    step("arb1_strb1", 3'b001, 8'h44, 1'b1, 1'b0, 1'b1, 8'h00);
    step("arb1_strb2", 3'b001, 8'h44, 1'b1, 1'b0, 1'b1, 8'h00);
    xr = 8'h99;
    step("arb1_done", 3'b011, 8'h44, 1'b1, 1'b1, 1'b1, 8'h00);
    step("arb2_cpu", 3'b001, 8'h22, 1'b0, 1'b0, 1'b1, 8'h00);
    cpu_set(1'b1, 8'h00, 1'b1, 1'b1);
    idle("arb2_rel", 1'b0);
    cpu_set(1'b0, 8'h23, 1'b0, 1'b1);
    idle("arb3_pick", 1'b1);
    step("arb3_setup", 3'b011, 8'h44, 1'b1, 1'b0, 1'b1, 8'h00);
    step("arb3_strb1", 3'b001, 8'h44, 1'b1, 1'b0, 1'b1, 8'h00);
    step("arb3_strb2", 3'b001, 8'h44, 1'b1, 1'b0, 1'b1, 8'h00);
    step("arb3_done", 3'b011, 8'h44, 1'b1, 1'b1, 1'b1, 8'h00);
    host_set(1'b0, 1'b0, 8'h44, 8'h00);
    step("arb4_cpu", 3'b001, 8'h23, 1'b0, 1'b0, 1'b1, 8'h00);
    cpu_set(1'b1, 8'h00, 1'b1, 1'b1);
    idle("arb4_rel", 1'b0);

    // CPU request arriving mid-strobe waits until the host returns to IDLE
    i_bus = 8'h3E;
    host_set(1'b1, 1'b0, 8'h10, 8'h00);
    idle("hs_idle", 1'b0);
    step("hs_setup", 3'b011, 8'h10, 1'b0, 1'b0, 1'b1, 8'h00);
    cpu_set(1'b0, 8'h33, 1'b1, 1'b0);
    step("hs_strb1", 3'b001, 8'h10, 1'b1, 1'b0, 1'b1, 8'h00);
    step("hs_strb2", 3'b001, 8'h10, 1'b1, 1'b0, 1'b1, 8'h00);
    xr = 8'h3E;
    step("hs_done", 3'b011, 8'h10, 1'b1, 1'b1, 1'b1, 8'h00);
    host_set(1'b0, 1'b0, 8'h10, 8'h00);
    step("hs_cpu", 3'b010, 8'h33, 1'b0, 1'b0, 1'b1, 8'h00);
    cpu_set(1'b1, 8'h00, 1'b1, 1'b1);
    idle("hs_rel", 1'b0);

    // Asynchronous reset in the strobe phase of a write
    host_set(1'b1, 1'b1, 8'h66, 8'hC3);
    idle("rs_idle", 1'b0);
    step("rs_setup", 3'b011, 8'h66, 1'b0, 1'b0, 1'b0, 8'hC3);
    i_resetn = 1'b0;
    host_set(1'b0, 1'b0, 8'h00, 8'h00);
    xr = 8'h00;
    idle("rs_assert", 1'b0);
    idle("rs_hold", 1'b0);
    i_resetn = 1'b1;
    idle("rs_release", 1'b0);

    // Next host read after reset runs from HSETUP
    i_bus = 8'h5C;
    host_set(1'b1, 1'b0, 8'h07, 8'h00);
    idle("nx_idle", 1'b0);
    step("nx_setup", 3'b011, 8'h07, 1'b0, 1'b0, 1'b1, 8'h00);
    step("nx_strb1", 3'b001, 8'h07, 1'b0, 1'b0, 1'b1, 8'h00);
    step("nx_strb2", 3'b001, 8'h07, 1'b0, 1'b0, 1'b1, 8'h00);
    xr = 8'h5C;
    step("nx_done", 3'b011, 8'h07, 1'b0, 1'b1, 1'b1, 8'h00);
    host_set(1'b0, 1'b0, 8'h07, 8'h00);
    idle("nx_after", 1'b0);

    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(posedge i_clk);
    end
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: actual=%0d pending required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
